// File: rtl/word_serializer.sv
// Parallel-to-serial converter: accepts words over valid/ready and emits one bit per
// clock with a valid strobe and end-of-word flag, using a one-word holding register.
module word_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("word_serializer: WIDTH must be in 2..32");
  end
  if (GAP < 0 || GAP > 15) begin : g_bad_gap
    $error("word_serializer: GAP must be in 0..15");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             hold_full_next;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bcnt;
  logic [3:0]       gcnt;
  logic             accept;
  logic             load;
  logic             head;
  logic             in_ready_next;
  logic             bit_out_next;
  logic             bit_valid_next;
  logic             last_bit_next;
  logic             busy_next;

  // The hold_full term keeps HOLD safe even if in_ready and hold_full ever disagree.
  assign accept = in_valid & in_ready & ~hold_full;
  assign head   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A load from HOLD happens either from IDLE or, with no gap, in place on the last bit.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        if (hold_full) begin
          load       = 1'b1;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bcnt == '0) begin
          if (GAP > 0) begin
            state_next = S_GAP;
          end else if (hold_full) begin
            load = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gcnt == 4'd0) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    hold_full_next = hold_full;
    if (load) begin
      hold_full_next = 1'b0;
    end else if (accept) begin
      hold_full_next = 1'b1;
    end
  end

  // busy also spans the cycle after leaving SHIFT/GAP so it drops once that output has settled.
  always_comb begin
    bit_out_next   = 1'b0;
    bit_valid_next = 1'b0;
    last_bit_next  = 1'b0;
    if (state == S_SHIFT) begin
      bit_out_next   = head;
      bit_valid_next = 1'b1;
      last_bit_next  = (bcnt == '0);
    end
    in_ready_next = ~hold_full_next;
    busy_next     = hold_full_next | (state_next != S_IDLE) | (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      bcnt      <= '0;
      gcnt      <= 4'd0;
    end else begin
      hold_full <= hold_full_next;
      if (accept) begin
        hold <= in_data;
      end
      if (load) begin
        shreg <= hold;
        bcnt  <= BW'(WIDTH - 1);
      end else if (state == S_SHIFT) begin
        shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
        bcnt  <= bcnt - BW'(1);
      end
      if (state == S_SHIFT && state_next == S_GAP) begin
        gcnt <= 4'((GAP > 0) ? (GAP - 1) : 0);
      end else if (state == S_GAP && gcnt != 4'd0) begin
        gcnt <= gcnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b1;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      last_bit  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= in_ready_next;
      bit_out   <= bit_out_next;
      bit_valid <= bit_valid_next;
      last_bit  <= last_bit_next;
      busy      <= busy_next;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: default, GAP=2 and LSB-first instances share one
// clock and reset, plus a 1010 Mealy detector fed from the default instance.
module tb_word_serializer;

  logic       clk;
  logic       reset;

  logic [7:0] a_in_data, g_in_data, l_in_data;
  logic       a_in_valid, g_in_valid, l_in_valid;
  logic       a_in_ready, g_in_ready, l_in_ready;
  logic       a_bit_out, g_bit_out, l_bit_out;
  logic       a_bit_valid, g_bit_valid, l_bit_valid;
  logic       a_last_bit, g_last_bit, l_last_bit;
  logic       a_busy, g_busy, l_busy;

  int n_checks = 0;
  int n_pass   = 0;

  word_serializer u_def (
    .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .bit_out(a_bit_out), .bit_valid(a_bit_valid),
    .last_bit(a_last_bit), .busy(a_busy)
  );

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(2)) u_gap (
    .clk(clk), .reset(reset), .in_data(g_in_data), .in_valid(g_in_valid),
    .in_ready(g_in_ready), .bit_out(g_bit_out), .bit_valid(g_bit_valid),
    .last_bit(g_last_bit), .busy(g_busy)
  );

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(0)) u_lsb (
    .clk(clk), .reset(reset), .in_data(l_in_data), .in_valid(l_in_valid),
    .in_ready(l_in_ready), .bit_out(l_bit_out), .bit_valid(l_bit_valid),
    .last_bit(l_last_bit), .busy(l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream overlapping 1010 Mealy detector with a registered output.
  logic [1:0] det_s;
  logic       det_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      det_s <= 2'd0;
      det_q <= 1'b0;
    end else begin
      det_q <= (det_s == 2'd3) && !a_bit_out;
      case (det_s)
        2'd0:    det_s <= a_bit_out ? 2'd1 : 2'd0;
        2'd1:    det_s <= a_bit_out ? 2'd1 : 2'd2;
        2'd2:    det_s <= a_bit_out ? 2'd3 : 2'd0;
        default: det_s <= a_bit_out ? 2'd1 : 2'd2;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = 8'hFF;
    g_in_valid = 1'b1;
    l_in_valid = 1'b1;
    tick();
    tick();
    reset      = 1'b0;
    a_in_valid = 1'b0;
    g_in_valid = 1'b0;
    l_in_valid = 1'b0;
    n_checks++;
    if ({a_in_ready, a_bit_out, a_bit_valid, a_last_bit, a_busy} !== 5'b10000)
      $display("[TB] FAIL reset_def got %b want 10000", {a_in_ready, a_bit_out, a_bit_valid, a_last_bit, a_busy});
    else n_pass++;
    n_checks++;
    if ({g_in_ready, g_bit_out, g_bit_valid, g_last_bit, g_busy} !== 5'b10000)
      $display("[TB] FAIL reset_gap got %b want 10000", {g_in_ready, g_bit_out, g_bit_valid, g_last_bit, g_busy});
    else n_pass++;
    n_checks++;
    if ({l_in_ready, l_bit_out, l_bit_valid, l_last_bit, l_busy} !== 5'b10000)
      $display("[TB] FAIL reset_lsb got %b want 10000", {l_in_ready, l_bit_out, l_bit_valid, l_last_bit, l_busy});
    else n_pass++;
    tick();
    tick();
    tick();
    n_checks++;
    if ({a_in_ready, a_bit_valid, a_busy} !== 3'b100)
      $display("[TB] FAIL reset_ignores_valid got %b want 100", {a_in_ready, a_bit_valid, a_busy});
    else n_pass++;
  endtask

  task automatic test_single_word();
    logic [7:0] pat;
    pat        = 8'hA5;
    a_in_data  = pat;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    n_checks++;
    if ({a_busy, a_in_ready, a_bit_valid} !== 3'b100)
      $display("[TB] FAIL single_accept got %b want 100", {a_busy, a_in_ready, a_bit_valid});
    else n_pass++;
    tick();
    n_checks++;
    if ({a_bit_valid, a_in_ready, a_busy} !== 3'b011)
      $display("[TB] FAIL single_load got %b want 011", {a_bit_valid, a_in_ready, a_busy});
    else n_pass++;
    tick();
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({a_bit_valid, a_bit_out, a_last_bit} !== {1'b1, pat[7-i], (i == 7)})
        $display("[TB] FAIL single_bit%0d got %b want %b", i, {a_bit_valid, a_bit_out, a_last_bit}, {1'b1, pat[7-i], (i == 7)});
      else n_pass++;
      if (i == 7) begin
        n_checks++;
        if (a_busy !== 1'b1) $display("[TB] FAIL single_busy_last got %b want 1", a_busy);
        else n_pass++;
      end
      tick();
    end
    n_checks++;
    if ({a_bit_valid, a_bit_out, a_last_bit, a_busy} !== 4'b0000)
      $display("[TB] FAIL single_after got %b want 0000", {a_bit_valid, a_bit_out, a_last_bit, a_busy});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] pat;
    pat        = 16'b1111000000001111;
    a_in_data  = 8'hF0;
    a_in_valid = 1'b1;
    tick();
    a_in_data = 8'h0F;
    n_checks++;
    if (a_in_ready !== 1'b0) $display("[TB] FAIL b2b_ready_after_accept got %b want 0", a_in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (a_in_ready !== 1'b1) $display("[TB] FAIL b2b_ready_after_load got %b want 1", a_in_ready);
    else n_pass++;
    tick();
    a_in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if ({a_bit_valid, a_bit_out, a_last_bit, a_in_ready} !== {1'b1, pat[15-i], (i == 7 || i == 15), (i >= 7)})
        $display("[TB] FAIL b2b_bit%0d got %b want %b", i, {a_bit_valid, a_bit_out, a_last_bit, a_in_ready},
                 {1'b1, pat[15-i], (i == 7 || i == 15), (i >= 7)});
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({a_bit_valid, a_busy, a_in_ready} !== 3'b001)
      $display("[TB] FAIL b2b_after got %b want 001", {a_bit_valid, a_busy, a_in_ready});
    else n_pass++;
  endtask

  task automatic test_gap();
    logic exp_v;
    g_in_data  = 8'hFF;
    g_in_valid = 1'b1;
    tick();
    tick();
    tick();
    g_in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      exp_v = (i < 8) || (i >= 11 && i < 19);
      n_checks++;
      if ({g_bit_valid, g_bit_out, g_last_bit} !== {exp_v, exp_v, (i == 7 || i == 18)})
        $display("[TB] FAIL gap_cycle%0d got %b want %b", i, {g_bit_valid, g_bit_out, g_last_bit},
                 {exp_v, exp_v, (i == 7 || i == 18)});
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_lsb_first();
    l_in_data  = 8'h01;
    l_in_valid = 1'b1;
    tick();
    l_in_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({l_bit_valid, l_bit_out, l_last_bit} !== {1'b1, (i == 0), (i == 7)})
        $display("[TB] FAIL lsb_bit%0d got %b want %b", i, {l_bit_valid, l_bit_out, l_last_bit}, {1'b1, (i == 0), (i == 7)});
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({l_bit_valid, l_last_bit} !== 2'b00)
      $display("[TB] FAIL lsb_after got %b want 00", {l_bit_valid, l_last_bit});
    else n_pass++;
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] pat;
    pat        = 8'hA5;
    a_in_data  = pat;
    a_in_valid = 1'b1;
    tick();
    a_in_data = 8'h3C;
    tick();
    tick();
    a_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({a_bit_valid, a_bit_out} !== {1'b1, pat[7-i]})
        $display("[TB] FAIL midrst_bit%0d got %b want %b", i, {a_bit_valid, a_bit_out}, {1'b1, pat[7-i]});
      else n_pass++;
      if (i < 2) tick();
    end
    reset      = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = 8'hC3;
    tick();
    reset      = 1'b0;
    a_in_valid = 1'b0;
    n_checks++;
    if ({a_bit_valid, a_in_ready, a_busy} !== 3'b010)
      $display("[TB] FAIL midrst_after_reset got %b want 010", {a_bit_valid, a_in_ready, a_busy});
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if ({a_bit_valid, a_busy} !== 2'b00)
      $display("[TB] FAIL midrst_held_discarded got %b want 00", {a_bit_valid, a_busy});
    else n_pass++;
    pat        = 8'hC3;
    a_in_data  = pat;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick();
    n_checks++;
    if (a_bit_valid !== 1'b0) $display("[TB] FAIL midrst_no_early_bit got %b want 0", a_bit_valid);
    else n_pass++;
    tick();
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({a_bit_valid, a_bit_out, a_last_bit} !== {1'b1, pat[7-i], (i == 7)})
        $display("[TB] FAIL midrst_new_bit%0d got %b want %b", i, {a_bit_valid, a_bit_out, a_last_bit}, {1'b1, pat[7-i], (i == 7)});
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({a_bit_valid, a_busy} !== 2'b00)
      $display("[TB] FAIL midrst_end got %b want 00", {a_bit_valid, a_busy});
    else n_pass++;
  endtask

  task automatic test_detector();
    logic [7:0] pat;
    logic       exp_b;
    do_reset();
    pat        = 8'hDA;
    a_in_data  = pat;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 12; i++) begin
      exp_b = 1'b0;
      if (i < 8) exp_b = pat[7-i];
      n_checks++;
      if ({a_bit_valid, a_bit_out, det_q} !== {(i < 8), exp_b, (i == 8)})
        $display("[TB] FAIL detect_cycle%0d got %b want %b", i, {a_bit_valid, a_bit_out, det_q}, {(i < 8), exp_b, (i == 8)});
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    reset      = 1'b0;
    a_in_data  = 8'h00;
    g_in_data  = 8'h00;
    l_in_data  = 8'h00;
    a_in_valid = 1'b0;
    g_in_valid = 1'b0;
    l_in_valid = 1'b0;
    tick();
    test_reset();
    test_single_word();
    tick();
    test_back_to_back();
    tick();
    test_gap();
    test_lsb_first();
    test_reset_mid_word();
    test_detector();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
